// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing defaults and receiver state encoding
package uart_pkg;

  localparam int DEF_TICKS_PER_BIT = 87;
  localparam int DEF_FRAME_WIDTH   = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - stream handshake carrying received UART words
interface uart_rx_if #(
  parameter int FRAME_WIDTH = 64
) ();

  logic [FRAME_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for async pins, resets to the idle-high level
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 1 start, FRAME_WIDTH data bits LSB first, 1 stop, stream output
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
  parameter int FRAME_WIDTH   = DEF_FRAME_WIDTH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  uart_rx_if.master   m_axis_rx,
  output logic        o_frame_err,
  output logic        o_overrun
);

  localparam int TW = $clog2(TICKS_PER_BIT) + 1;
  localparam int BW = $clog2(FRAME_WIDTH) + 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(TICKS_PER_BIT / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_WIDTH - 1);

  logic                   w_rx_s;
  rx_state_t              r_state;
  logic [TW-1:0]          r_tick;
  logic [BW-1:0]          r_bit;
  logic [FRAME_WIDTH-1:0] r_shift;
  logic [FRAME_WIDTH-1:0] r_tdata;
  logic                   r_tvalid;
  logic                   r_frame_err;
  logic                   r_overrun;

  uart_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_tvalid && m_axis_rx.tready) r_tvalid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_tick <= '0;
          r_bit  <= '0;
          if (!w_rx_s) r_state <= START;
        end

        START: begin
          if (r_tick == TICK_MID) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        // Shift right so the first (LSB) bit ends up in bit 0 after the last sample.
        DATA: begin
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_shift <= {w_rx_s, r_shift[FRAME_WIDTH-1:1]};
            if (r_bit == BIT_LAST) begin
              r_bit   <= '0;
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        // Leaving at mid-stop-bit leaves half a bit of margin for the next start edge.
        STOP: begin
          if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            if (w_rx_s) begin
              if (!r_tvalid || m_axis_rx.tready) begin
                r_tdata  <= r_shift;
                r_tvalid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        BREAK: begin
          r_tick <= '0;
          r_bit  <= '0;
          if (w_rx_s) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis_rx.tdata  = r_tdata;
  assign m_axis_rx.tvalid = r_tvalid;
  assign o_frame_err      = r_frame_err;
  assign o_overrun        = r_overrun;

endmodule
